load_store_unit: RTL and testbench

- Sits between the execute/memory pipeline stage and the word-organised data memory.
- Accepts byte-addressed load/store requests of size byte, half or word, and checks alignment.
- Maps each request onto whole-word memory accesses, using read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data to the requester over a valid/ready response handshake.

---
 rtl/load_store_unit_pkg.sv | 17 +
 rtl/lsu_align.sv | 27 ++
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access-size and FSM state encodings plus data-memory depth shared by the LSU and the data memory.
package load_store_unit_pkg;
    localparam int DMEM_BITS = 10;
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_e;
    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_RD,
        LSU_MERGE,
        LSU_WR,
        LSU_RESP
    } lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/half lane extract with sign or zero extension for loads, and lane merge into a word for stores.
// Ports: size (access size), is_unsigned (zero-extend loads), offset (byte address bits [1:0]),
//        word (memory word), wdata (right-aligned store data), rdata (extended load data), merged (word with lane replaced).
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask;
    assign sh = {offset, 3'b000};
    assign b = 8'(word >> sh);
    assign h = offset[1] ? word[31:16] : word[15:0];
    assign bmask = 32'h0000_00ff << sh;
    assign rdata = size == SIZE_BYTE ? {{24{b[7] & ~is_unsigned}}, b} :
                   size == SIZE_HALF ? {{16{h[15] & ~is_unsigned}}, h} : word;
    assign merged = size == SIZE_BYTE ? (word & ~bmask) | ({24'b0, wdata[7:0]} << sh) :
                    size == SIZE_HALF ? (offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) : wdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-organised data memory, with read-modify-write for sub-word stores.
// Ports: clk, reset (async, active-high); req_* request handshake (we, size, unsigned, addr, wdata);
//        resp_* response handshake (rdata, err); mem_* registered word-memory interface with combinational mem_data_out.
module load_store_unit #(
    parameter int DMEM_BITS = load_store_unit_pkg::DMEM_BITS,
    parameter bit RMW_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    import load_store_unit_pkg::*;
    lsu_state_e  state;
    logic        we_q, uns_q, accept, bad, unused_addr;
    logic [1:0]  size_q, off_q;
    logic [31:0] wdata_q, word_q, align_rdata, align_merged;
    assign req_ready = state == LSU_IDLE && !reset;
    assign accept = req_valid && req_ready;
    assign bad = req_size == SIZE_RSVD || (req_size == SIZE_HALF && req_addr[0]) ||
                 (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) ||
                 (!RMW_EN && req_we && req_size != SIZE_WORD);
    // address bits above the memory depth wrap silently
    assign unused_addr = ^req_addr[31:DMEM_BITS+2];
    // RD extracts straight from the memory read port; MERGE works on the captured word
    lsu_align u_align (
        .size(size_q),
        .is_unsigned(uns_q),
        .offset(off_q),
        .word(state == LSU_MERGE ? word_q : mem_data_out),
        .wdata(wdata_q),
        .rdata(align_rdata),
        .merged(align_merged)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LSU_IDLE;
            we_q <= 1'b0;
            uns_q <= 1'b0;
            size_q <= 2'b00;
            off_q <= 2'b00;
            wdata_q <= '0;
            word_q <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
            mem_addr <= '0;
            mem_write_en <= 1'b0;
            mem_data_in <= '0;
        end else begin
            case (state)
                LSU_IDLE: if (accept) begin
                    we_q <= req_we;
                    size_q <= req_size;
                    uns_q <= req_unsigned;
                    off_q <= req_addr[1:0];
                    wdata_q <= req_wdata;
                    resp_rdata <= '0;
                    resp_err <= bad;
                    if (bad) begin
                        resp_valid <= 1'b1;
                        state <= LSU_RESP;
                    end else begin
                        mem_addr <= 32'(req_addr[DMEM_BITS+1:2]);
                        if (req_we && req_size == SIZE_WORD) begin
                            mem_data_in <= req_wdata;
                            mem_write_en <= 1'b1;
                            state <= LSU_WR;
                        end else begin
                            state <= LSU_RD;
                        end
                    end
                end
                LSU_RD: begin
                    word_q <= mem_data_out;
                    if (we_q) begin
                        state <= LSU_MERGE;
                    end else begin
                        resp_rdata <= align_rdata;
                        resp_valid <= 1'b1;
                        state <= LSU_RESP;
                    end
                end
                LSU_MERGE: begin
                    mem_data_in <= align_merged;
                    mem_write_en <= 1'b1;
                    state <= LSU_WR;
                end
                LSU_WR: begin
                    mem_write_en <= 1'b0;
                    resp_valid <= 1'b1;
                    state <= LSU_RESP;
                end
                LSU_RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_write_en;
    logic [31:0] resp_rdata, mem_addr, mem_data_in, mem_data_out;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } item_t;

    item_t       sb[$];
    logic [31:0] dmem [1024];
    logic [7:0]  rb [4096];
    int          checks = 0, errors = 0, cyc = 0, wr_cycles = 0, first_cyc = 0;
    logic [31:0] exp_waddr = '0, held_rd = '0;
    logic        held_err = 1'b0, prev_valid = 1'b0;

    load_store_unit #(.DMEM_BITS(10), .RMW_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_write_en) dmem[mem_addr[9:0]] <= mem_data_in;
    assign mem_data_out = dmem[mem_addr[9:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat byte array, sizes as byte counts.
    function automatic void ref_op(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                                   input logic [31:0] wd, output logic [31:0] rd, output logic err,
                                   output int lat, output int nwr);
        int n, base;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        base = int'(a & 32'hfff);
        err = sz == 2'd3 || base % n != 0;
        rd = '0;
        nwr = 0;
        lat = 1;
        if (!err && we) begin
            for (int i = 0; i < n; i++) rb[base + i] = wd[8*i +: 8];
            nwr = 1;
            lat = n == 4 ? 2 : 4;
        end else if (!err) begin
            for (int i = 0; i < n; i++) rd = rd | (32'(rb[base + i]) << (8 * i));
            if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
            lat = 2;
        end
    endfunction

    task automatic recover();
        reset = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        item_t it;
        int nwr, w0;
        ref_op(we, sz, uns, a, wd, it.rd, it.err, it.lat, nwr);
        exp_waddr = (a >> 2) & 32'h3ff;
        w0 = wr_cycles;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        if (!req_ready) begin
            chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
            recover();
            return;
        end
        @(posedge clk);
        #1;
        it.acc = cyc;
        sb.push_back(it);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 0; k < 12 && !resp_valid; k++) @(negedge clk);
        if (!resp_valid) begin
            chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
            recover();
            return;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("write_cycles", 32'(wr_cycles - w0), 32'(nwr));
    endtask

    // Reset while the sub-word store sits in MERGE: no write, no response.
    task automatic rmw_reset(input logic [31:0] a, input logic [31:0] wd);
        int w0;
        w0 = wr_cycles;
        exp_waddr = (a >> 2) & 32'h3ff;
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        chk("rmw_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rmw_rst_we", {31'b0, mem_write_en}, 32'd0);
        chk("rmw_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rmw_rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rmw_rst_addr", mem_addr, 32'd0);
        chk("rmw_rst_din", mem_data_in, 32'd0);
        chk("rmw_rst_rdata", resp_rdata, 32'd0);
        chk("rmw_rst_err", {31'b0, resp_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rmw_post_ready", {31'b0, req_ready}, 32'd1);
        chk("rmw_no_write", 32'(wr_cycles - w0), 32'd0);
    endtask

    // Reset during the write cycle of a word store: the strobe must fall without a clock edge.
    task automatic wr_reset(input logic [31:0] a, input logic [31:0] wd);
        int w0;
        w0 = wr_cycles;
        exp_waddr = (a >> 2) & 32'h3ff;
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("wr_strobe_high", {31'b0, mem_write_en}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("wr_async_drop", {31'b0, mem_write_en}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("wr_post_ready", {31'b0, req_ready}, 32'd1);
        chk("wr_no_write", 32'(wr_cycles - w0), 32'd0);
    endtask

    always @(negedge clk) begin
        item_t it;
        if (mem_write_en) begin
            wr_cycles++;
            chk("mem_addr_at_write", mem_addr, exp_waddr);
        end
        if (resp_valid && !prev_valid) begin
            first_cyc = cyc;
            held_rd = resp_rdata;
            held_err = resp_err;
        end else if (resp_valid) begin
            chk("hold_rdata", resp_rdata, held_rd);
            chk("hold_err", {31'b0, resp_err}, {31'b0, held_err});
        end
        if (resp_valid && !resp_ready) chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                it = sb.pop_front();
                chk("resp_rdata", resp_rdata, it.rd);
                chk("resp_err", {31'b0, resp_err}, {31'b0, it.err});
                chk("latency", 32'(first_cyc - it.acc + 1), 32'(it.lat));
            end
        end
        prev_valid = resp_valid;
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a, w;
        int          r, n, bad;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int j = 0; j < 4; j++) rb[4*i + j] = w[8*j +: 8];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_write_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_data_in, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

        do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hdeadbeef, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        do_txn(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000aa, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        do_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        do_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
        do_txn(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0);
        do_txn(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
        do_txn(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000cafe, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'hffff_f020, 32'h0, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        rmw_reset(32'h11, 32'h00000055);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        wr_reset(32'h30, 32'h0badf00d);
        do_txn(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            sz = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
            n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
            a = ($urandom & 32'hffff_f000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (dmem[i] !== {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]}) bad++;
        chk("final_memory_words_bad", 32'(bad), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
